mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// The arbiter takes the slave view; a requester/memory model takes the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // Requester side
  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_rvalid0;
  logic              o_rvalid1;
  logic [DATA_W-1:0] o_rdata;
  logic              o_err;

  // Memory side
  logic              o_mem_wr;
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rd_data;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mem_rd_data,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata, o_err,
           o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mem_rd_data,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata, o_err,
           o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a small
// register-file memory with a one-cycle registered read. Out-of-range
// accesses are flagged with o_err and never strobe the memory.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic          i_sys_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic              last_q, last_d;     // id of the requester served last
  logic              id_q, id_d;         // owner of the transaction in flight
  logic              we_q, we_d;
  logic              oor_q, oor_d;       // in-flight access is out of range

  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Requester fields gathered into indexable vectors so the winner can be
  // selected by id.
  logic [1:0]        req_v;
  logic [1:0]        we_v;
  logic [1:0]        oor_v;
  logic [ADDR_W-1:0] addr_v  [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic              win;

  assign req_v      = {bus.i_req1, bus.i_req0};
  assign we_v       = {bus.i_we1, bus.i_we0};
  assign addr_v[0]  = bus.i_addr0;
  assign addr_v[1]  = bus.i_addr1;
  assign wdata_v[0] = bus.i_wdata0;
  assign wdata_v[1] = bus.i_wdata1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_range
      assign oor_v[gi] = ({1'b0, addr_v[gi]} >= DEPTH_LIM);
    end
  endgenerate

  // Next-state and next-output logic; every output is registered, so the
  // values computed in IDLE become visible during ISSUE.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    oor_d       = oor_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    err_d       = 1'b0;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    win         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_v != 2'b00) begin
          // On a tie the requester not served last wins.
          win         = (req_v == 2'b11) ? ~last_q : req_v[1];
          id_d        = win;
          we_d        = we_v[win];
          oor_d       = oor_v[win];
          mem_addr_d  = addr_v[win];
          mem_wdata_d = wdata_v[win];
          gnt0_d      = ~win;
          gnt1_d      = win;
          err_d       = oor_v[win];
          mem_wr_d    = we_v[win] & ~oor_v[win];
          mem_rd_d    = ~we_v[win] & ~oor_v[win];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        last_d  = id_q;
        state_d = we_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        rdata_d   = oor_q ? '0 : bus.i_mem_rd_data;
        rvalid0_d = ~id_q;
        rvalid1_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and points the
  // last-served pointer at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.o_gnt0      = gnt0_q;
  assign bus.o_gnt1      = gnt1_q;
  assign bus.o_rvalid0   = rvalid0_q;
  assign bus.o_rvalid1   = rvalid1_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_err       = err_q;
  assign bus.o_mem_wr    = mem_wr_q;
  assign bus.o_mem_rd    = mem_rd_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives both requesters, models the
// register-file memory, and checks grants, strobes, read data and errors.
module tb_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on strobe, one-cycle registered read.
  logic [DATA_W-1:0] mem_q [16];
  always @(posedge clk) begin
    if (bus.o_mem_wr) mem_q[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_rd) bus.i_mem_rd_data <= mem_q[bus.o_mem_addr];
  end

  // Advance one cycle and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},
        {28'd0, bus.o_gnt0, bus.o_gnt1, bus.o_rvalid0, bus.o_rvalid1}, 32'd0);
    chk({tag, "_str"}, {29'd0, bus.o_err, bus.o_mem_wr, bus.o_mem_rd}, 32'd0);
    chk({tag, "_rdata"}, 32'(bus.o_rdata), 32'd0);
    chk({tag, "_addr"}, 32'(bus.o_mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.o_mem_wdata), 32'd0);
  endtask

  logic [7:0] exp_g0;
  logic [7:0] exp_g1;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.i_req0 = 1'b0; bus.i_we0 = 1'b0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
    bus.i_req1 = 1'b0; bus.i_we1 = 1'b0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
    bus.i_mem_rd_data = '0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Requester 0 writes 0xA5 to addr 2
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 4'd2; bus.i_wdata0 = 8'hA5;
    tick();
    chk("wr_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("wr_gnt1", 32'(bus.o_gnt1), 32'd0);
    chk("wr_strobe", 32'(bus.o_mem_wr), 32'd1);
    chk("wr_addr", 32'(bus.o_mem_addr), 32'd2);
    chk("wr_wdata", 32'(bus.o_mem_wdata), 32'hA5);
    chk("wr_err", 32'(bus.o_err), 32'd0);
    bus.i_req0 = 1'b0;
    tick();
    chk("wr_strobe_off", 32'(bus.o_mem_wr), 32'd0);
    chk("wr_addr_hold", 32'(bus.o_mem_addr), 32'd2);

    // Requester 0 reads addr 2
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 4'd2;
    tick();
    chk("rd_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("rd_strobe", 32'(bus.o_mem_rd), 32'd1);
    bus.i_req0 = 1'b0;
    tick();
    chk("rd_rvalid_early", 32'(bus.o_rvalid0), 32'd0);
    tick();
    chk("rd_rvalid0", 32'(bus.o_rvalid0), 32'd1);
    chk("rd_rdata", 32'(bus.o_rdata), 32'hA5);
    chk("rd_strobe_off", 32'(bus.o_mem_rd), 32'd0);

    // Requester 1 stores 0x3C at addr 3
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b1; bus.i_addr1 = 4'd3; bus.i_wdata1 = 8'h3C;
    tick();
    chk("pre_gnt1", 32'(bus.o_gnt1), 32'd1);
    chk("pre_strobe", 32'(bus.o_mem_wr), 32'd1);
    bus.i_req1 = 1'b0;
    tick();

    // Requester 1 reads addr 3; requester 0 asks for a write one cycle later
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b0; bus.i_addr1 = 4'd3;
    tick();
    chk("mix_gnt1", 32'(bus.o_gnt1), 32'd1);
    bus.i_req1 = 1'b0;
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 4'd0; bus.i_wdata0 = 8'h11;
    tick();
    chk("mix_wait1", 32'(bus.o_gnt0), 32'd0);
    tick();
    chk("mix_rvalid1", 32'(bus.o_rvalid1), 32'd1);
    chk("mix_rdata", 32'(bus.o_rdata), 32'h3C);
    chk("mix_wait2", 32'(bus.o_gnt0), 32'd0);
    tick();
    chk("mix_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("mix_rdata_hold", 32'(bus.o_rdata), 32'h3C);
    chk("mix_rvalid1_off", 32'(bus.o_rvalid1), 32'd0);
    bus.i_req0 = 1'b0;
    tick();

    // Both requesters write continuously from reset
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 4'd0; bus.i_wdata0 = 8'h10;
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b1; bus.i_addr1 = 4'd1; bus.i_wdata1 = 8'h20;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_g0 = 8'b0001_0001;
    exp_g1 = 8'b0100_0100;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) begin
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
      end
      tick();
      chk($sformatf("rr_g0_c%0d", c + 1), 32'(bus.o_gnt0), 32'(exp_g0[c]));
      chk($sformatf("rr_g1_c%0d", c + 1), 32'(bus.o_gnt1), 32'(exp_g1[c]));
      if (exp_g1[c]) chk($sformatf("rr_addr_c%0d", c + 1), 32'(bus.o_mem_addr), 32'd1);
      if (exp_g0[c]) chk($sformatf("rr_addr_c%0d", c + 1), 32'(bus.o_mem_addr), 32'd0);
    end
    tick();

    // Out-of-range read at addr 7
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 4'd7;
    tick();
    chk("oor_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("oor_err", 32'(bus.o_err), 32'd1);
    chk("oor_no_rd", 32'(bus.o_mem_rd), 32'd0);
    bus.i_req0 = 1'b0;
    tick();
    chk("oor_err_off", 32'(bus.o_err), 32'd0);
    tick();
    chk("oor_rvalid0", 32'(bus.o_rvalid0), 32'd1);
    chk("oor_rdata", 32'(bus.o_rdata), 32'h00);

    // Out-of-range write at addr 5
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 4'd5; bus.i_wdata0 = 8'h77;
    tick();
    chk("oorw_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("oorw_err", 32'(bus.o_err), 32'd1);
    chk("oorw_no_wr", 32'(bus.o_mem_wr), 32'd0);
    bus.i_req0 = 1'b0;
    tick();
    chk("oorw_idle", 32'(bus.o_err), 32'd0);

    // Reset during RWAIT of a read (requester 0 was served last)
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 4'd2;
    tick();
    chk("abort_gnt0", 32'(bus.o_gnt0), 32'd1);
    bus.i_req0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("abort");
    rst = 1'b0;
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 4'd1; bus.i_wdata0 = 8'h66;
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b1; bus.i_addr1 = 4'd2; bus.i_wdata1 = 8'h99;
    tick();
    chk("post_rst_gnt0", 32'(bus.o_gnt0), 32'd1);
    chk("post_rst_gnt1", 32'(bus.o_gnt1), 32'd0);
    chk("post_rst_no_rvalid", 32'(bus.o_rvalid0), 32'd0);
    bus.i_req0 = 1'b0;
    tick();
    tick();
    chk("post_rst_gnt1b", 32'(bus.o_gnt1), 32'd1);
    bus.i_req1 = 1'b0;
    tick();

    // Requester 1 holds req high; requester 0 joins midway and wins the tie
    bus.i_we1 = 1'b1; bus.i_addr1 = 4'd1; bus.i_wdata1 = 8'h44;
    bus.i_we0 = 1'b1; bus.i_addr0 = 4'd0; bus.i_wdata0 = 8'h55;
    exp_g1 = 8'b0100_0101;
    exp_g0 = 8'b0001_0000;
    for (int c = 0; c < 8; c++) begin
      bus.i_req1 = (c <= 6);
      bus.i_req0 = (c == 3) || (c == 4);
      tick();
      chk($sformatf("hold_g1_c%0d", c + 1), 32'(bus.o_gnt1), 32'(exp_g1[c]));
      chk($sformatf("hold_g0_c%0d", c + 1), 32'(bus.o_gnt0), 32'(exp_g0[c]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
